// File: rtl/alu_operand_loader_pkg.sv
// alu_loader_pkg: shared types and default widths for the ALU operand loader.
//   state_e      - loader FSM states, in byte/phase order
//   DEF_DATA_W   - default operand/result width
//   DEF_OP_W     - default ALU op width
package alu_loader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 2;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_e;

endpackage

// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: byte input stream and result output stream of the loader.
//   in_valid/in_data/in_ready      - byte stream (a, then b, then op)
//   res_valid/res_data/res_err/res_ready - captured ALU result stream
//   slave  - loader side; master - producer/consumer side
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high. Once valid is raised the sender holds valid and data stable until that edge;
// ready may change freely and never depends combinationally on valid.
interface alu_operand_loader_if
    import alu_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              res_ready;

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects {a, b, op} bytes, holds them as registered operands
// for an external combinational ALU for EXEC_CYCLES, then captures and offers the
// ALU result.
//   clk, rst_n      - clock, asynchronous active-low reset
//   flush           - synchronous abort back to S_A
//   bus (slave)     - byte input stream and result output stream
//   alu_a/b/op      - registered operands to the ALU
//   alu_out         - combinational ALU result
//   busy            - high whenever the FSM is not in S_A
//   txn_count       - completed result handshakes, modulo 256
//   state           - current FSM state (debug visibility)
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OP_W        = DEF_OP_W,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    alu_operand_loader_if.slave   bus,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_op,
    input  logic [DATA_W-1:0]     alu_out,
    output logic                  busy,
    output logic [7:0]            txn_count,
    output state_e                state
);

    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    if (EXEC_CYCLES < 1) begin : g_bad_exec
        $error("alu_operand_loader: EXEC_CYCLES must be >= 1");
    end

    logic [CNT_W-1:0] exec_cnt;

    // in_ready and busy are registered alongside state: every transition below sets
    // them to the values belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_A;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            exec_cnt      <= '0;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_err   <= 1'b0;
            busy          <= 1'b0;
            txn_count     <= '0;
        end else begin
            // A result handshake is counted even when flush arrives on the same edge.
            if (bus.res_valid && bus.res_ready) begin
                txn_count <= txn_count + 8'd1;
            end

            if (flush) begin
                state         <= S_A;
                bus.in_ready  <= 1'b1;
                bus.res_valid <= 1'b0;
                bus.res_err   <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (state)
                    S_A: begin
                        if (bus.in_valid && bus.in_ready) begin
                            alu_a <= bus.in_data;
                            state <= S_B;
                            busy  <= 1'b1;
                        end
                    end
                    S_B: begin
                        if (bus.in_valid && bus.in_ready) begin
                            alu_b <= bus.in_data;
                            state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (bus.in_valid && bus.in_ready) begin
                            alu_op       <= bus.in_data[OP_W-1:0];
                            // Any set bit above the op field marks the request malformed.
                            bus.res_err  <= |bus.in_data[DATA_W-1:OP_W];
                            exec_cnt     <= CNT_W'(EXEC_CYCLES - 1);
                            bus.in_ready <= 1'b0;
                            state        <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (exec_cnt == '0) begin
                            bus.res_data  <= alu_out;
                            bus.res_valid <= 1'b1;
                            state         <= S_RES;
                        end else begin
                            exec_cnt <= exec_cnt - 1'b1;
                        end
                    end
                    S_RES: begin
                        if (bus.res_valid && bus.res_ready) begin
                            bus.res_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            busy          <= 1'b0;
                            state         <= S_A;
                        end
                    end
                    default: begin
                        state         <= S_A;
                        bus.in_ready  <= 1'b1;
                        bus.res_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
